// File: rtl/aplic_pkg.sv
// rtl/aplic_pkg.sv - APLIC source-mode encoding and per-mode helper functions
//
// Contents:
//   sm_e          sourcecfg.SM encoding (2 and 3 are reserved and decode as inactive)
//   is_edge()     true for EDGE1 / EDGE0
//   is_level()    true for LEVEL1 / LEVEL0
//   rectify()     rectified source value for a given mode and sampled level
package aplic_pkg;

  typedef enum logic [2:0] {
    INACTIVE = 3'd0,
    DETACHED = 3'd1,
    EDGE1    = 3'd4,
    EDGE0    = 3'd5,
    LEVEL1   = 3'd6,
    LEVEL0   = 3'd7
  } sm_e;

  function automatic logic is_edge(logic [2:0] sm);
    return (sm == EDGE1) || (sm == EDGE0);
  endfunction

  function automatic logic is_level(logic [2:0] sm);
    return (sm == LEVEL1) || (sm == LEVEL0);
  endfunction

  // Bit 0 of the mode selects the inverted polarity (EDGE0, LEVEL0).
  // Non-active modes always read as 0, so they never generate an event.
  function automatic logic rectify(logic [2:0] sm, logic s);
    if (is_edge(sm) || is_level(sm)) begin
      return s ^ sm[0];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/aplic_glitch_filter.sv
// rtl/aplic_glitch_filter.sv - single-bit glitch filter, stable value changes after FilterCycles agreeing samples
//
// Ports:
//   i_clk     clock
//   i_rst     asynchronous reset, active-high
//   i_raw     raw synchronized input level
//   o_stable  filtered level, toggles once i_raw has differed from it for FilterCycles samples
module aplic_glitch_filter #(
  parameter int FilterCycles = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CntW = (FilterCycles > 2) ? $clog2(FilterCycles) : 1;

  logic [CntW-1:0] cnt_q;

  // The counter holds the number of consecutive differing samples already
  // seen; the sample that would make it FilterCycles flips the stable value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stable <= 1'b0;
      cnt_q    <= '0;
    end else if (i_raw == o_stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(FilterCycles - 1)) begin
      o_stable <= ~o_stable;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/aplic_irq_gateway.sv
// rtl/aplic_irq_gateway.sv - per-source APLIC gateway: mode qualification and held set-pending requests
//
// Optional feature macro: APLIC_GATEWAY_FILTER_EN (per-source glitch filter on the sampled input)
//
// Ports:
//   i_clk          clock
//   i_rst          asynchronous reset, active-high
//   i_irq_sources  synchronized source levels, bit i = APLIC source i+1
//   i_sm           sourcecfg.SM per source, 3 bits each, source i at [3*i +: 3]
//   i_setip_ack    domain consumed the request this cycle
//   o_setip_req    registered set-pending request per source
//   o_rectified    registered rectified source value (in_clrip readback)
module aplic_irq_gateway
  import aplic_pkg::*;
#(
  parameter int NrSources    = 32,
  parameter int FilterCycles = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NrSources-1:0]   i_irq_sources,
  input  logic [NrSources*3-1:0] i_sm,
  input  logic [NrSources-1:0]   i_setip_ack,
  output logic [NrSources-1:0]   o_setip_req,
  output logic [NrSources-1:0]   o_rectified
);

  if (FilterCycles < 2 || FilterCycles > 15) begin : g_bad_filter_cycles
    $error("aplic_irq_gateway: FilterCycles must be in 2..15");
  end

  logic [NrSources-1:0] s;
  logic [NrSources-1:0] r;
  logic [NrSources-1:0] ev;
  logic [NrSources-1:0] active;
  logic [NrSources-1:0] prev_q;

`ifdef APLIC_GATEWAY_FILTER_EN
  for (genvar i = 0; i < NrSources; i++) begin : g_filter
    aplic_glitch_filter #(
      .FilterCycles (FilterCycles)
    ) u_filter (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (i_irq_sources[i]),
      .o_stable (s[i])
    );
  end
`else
  assign s = i_irq_sources;
`endif

  // Level events only fire while the request is low, so an ack always
  // clears a level request for one cycle before an active input re-raises
  // it. Edge events override a same-cycle ack.
  always_comb begin
    active = '0;
    r      = '0;
    ev     = '0;
    for (int i = 0; i < NrSources; i++) begin
      active[i] = is_edge(i_sm[3*i +: 3]) || is_level(i_sm[3*i +: 3]);
      r[i]      = rectify(i_sm[3*i +: 3], s[i]);
      if (is_edge(i_sm[3*i +: 3])) begin
        ev[i] = r[i] & ~prev_q[i];
      end else begin
        ev[i] = r[i] & ~o_setip_req[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q      <= '0;
      o_setip_req <= '0;
    end else begin
      prev_q <= r;
      for (int i = 0; i < NrSources; i++) begin
        if (!active[i]) begin
          o_setip_req[i] <= 1'b0;
        end else if (ev[i]) begin
          o_setip_req[i] <= 1'b1;
        end else if (i_setip_ack[i]) begin
          o_setip_req[i] <= 1'b0;
        end
      end
    end
  end

  // The previous-sample register already holds r delayed by one cycle,
  // which is exactly the registered rectified readback.
  assign o_rectified = prev_q;

endmodule
